// File: rtl/game_timer_ctrl.sv
// -----------------------------------------------------------------------------
// game_timer_ctrl
//
// Control stage that sits in front of the BCD game countdown timer (99..0).
// It produces the timer's load strobe when a game starts. It produces the
// one-second count enable and the run/pause gate. It also produces the +10 s
// bonus strobes. It watches the timer's digits and terminal count to detect
// time-up and the low-time warning.
//
// Configuration macro:
//   GAME_TIMER_WARN_BLINK_EN  - when defined, low_time_warn blinks. It is high
//                               during the first half of each game second and
//                               its level freezes while paused. When undefined,
//                               low_time_warn is a steady level.
//
// Ports:
//   clk            in   1  system clock
//   reset          in   1  asynchronous, active-high reset
//   start_game     in   1  pulse: (re)start countdown from timer preset
//   pause_toggle   in   1  pulse: RUN <-> PAUSED
//   bonus_pickup   in   1  pulse: player took a +10 s item
//   countH         in   4  timer tens digit (BCD)
//   countL         in   4  timer units digit (BCD)
//   tc             in   1  timer terminal count
//   timer_loadN    out  1  active-low preset load to timer
//   one_sec_en     out  1  one-cycle enable, once per game second
//   run_en         out  1  high while running
//   inc_time       out  1  one-cycle +10 s strobe to timer (registered)
//   time_up        out  1  high once time has expired
//   low_time_warn  out  1  low-time indicator for HUD (registered)
//   bonus_pending  out  3  queued bonuses not yet applied
//   fsm_state      out  3  current FSM state (debug observation)
//
// Handshakes: all inputs are single-cycle pulses sampled on the rising clock
// edge. There is no backpressure. The timer accepts inc_time and one_sec_en
// on the edge that closes the cycle in which they are high.
// -----------------------------------------------------------------------------
module game_timer_ctrl #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int BONUS_Q_MAX   = 7,
    parameter int WARN_SECONDS  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_game,
    input  logic       pause_toggle,
    input  logic       bonus_pickup,
    input  logic [3:0] countH,
    input  logic [3:0] countL,
    input  logic       tc,
    output logic       timer_loadN,
    output logic       one_sec_en,
    output logic       run_en,
    output logic       inc_time,
    output logic       time_up,
    output logic       low_time_warn,
    output logic [2:0] bonus_pending,
    output logic [2:0] fsm_state
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN     = 3'd2,
        S_PAUSED  = 3'd3,
        S_EXPIRED = 3'd4
    } state_t;

    state_t         state, state_next;
    logic [PW-1:0]  presc;
    logic [2:0]     pending;
    logic           presc_last;
    logic           count_zero;
    logic [6:0]     remaining;
    logic           active, stay_active;
    logic           issue, pickup_ok;
    logic           expire;
    logic           warn_cond, warn_next;

    // A digit outside BCD range is treated as 9.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign remaining  = 7'(bcd_clamp(countH)) * 7'd10 + 7'(bcd_clamp(countL));
    assign count_zero = (countH == 4'd0) && (countL == 4'd0);
    assign presc_last = (presc == PW'(TICKS_PER_SEC - 1));

    assign active      = (state == S_RUN) || (state == S_PAUSED);
    assign stay_active = (state_next == S_RUN) || (state_next == S_PAUSED);
    assign pickup_ok   = bonus_pickup && active;
    // The strobe spacing gives the timer one quiet cycle to settle. No strobe
    // is issued on the way into LOAD, because the preset would overwrite it.
    assign issue       = active && stay_active && (pending != 3'd0) && !inc_time;
    // A strobe that is still in flight counts as a bonus that is not yet
    // applied. It keeps the game alive at 00.
    assign expire      = tc && count_zero && (pending == 3'd0) && !inc_time;

    assign warn_cond = active && (remaining != 7'd0) && (remaining <= 7'(WARN_SECONDS));
`ifdef GAME_TIMER_WARN_BLINK_EN
    // The prescaler holds while paused, so the blink phase freezes with it.
    assign warn_next = warn_cond && (presc < PW'(TICKS_PER_SEC / 2));
`else
    assign warn_next = warn_cond;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start_game outranks pause and time-up
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start_game) state_next = S_LOAD;
            S_LOAD:    state_next = S_RUN;
            S_RUN: begin
                if (start_game)        state_next = S_LOAD;
                else if (pause_toggle) state_next = S_PAUSED;
                else if (expire)       state_next = S_EXPIRED;
            end
            S_PAUSED: begin
                if (start_game)        state_next = S_LOAD;
                else if (pause_toggle) state_next = S_RUN;
            end
            S_EXPIRED: if (start_game) state_next = S_LOAD;
            default:   state_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        timer_loadN = (state != S_LOAD);
        run_en      = (state == S_RUN);
        time_up     = (state == S_EXPIRED);
        // Skip the tick at 00 so the timer never wraps. Also skip it while a
        // bonus lands so the timer never sees both commands in one cycle.
        one_sec_en  = (state == S_RUN) && presc_last && !count_zero && !inc_time;
    end

    assign bonus_pending = pending;
    assign fsm_state     = state;

    // Prescaler: advances only in RUN and holds in PAUSED, so no fraction of a
    // second is lost. It restarts from 0 on every load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (state == S_LOAD) begin
            presc <= '0;
        end else if (state == S_RUN) begin
            presc <= presc_last ? '0 : presc + PW'(1);
        end
    end

    // Bonus queue and strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= 3'd0;
            inc_time <= 1'b0;
        end else begin
            inc_time <= issue;
            if (state_next == S_LOAD) begin
                pending <= 3'd0;
            end else if (pickup_ok && !issue) begin
                if (pending != 3'(BONUS_Q_MAX)) pending <= pending + 3'd1;
            end else if (issue && !pickup_ok) begin
                pending <= pending - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_time_warn <= 1'b0;
        end else begin
            low_time_warn <= warn_next;
        end
    end

endmodule
